// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer that owns the select of the shared 4:1 one-bit mux.
// Optional per-grant hold limit compiled in with `define MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] REQ,
    input  logic [3:0] D,
    output logic [1:0] S,
    output logic [3:0] GNT,
    output logic       Q,
    output logic       V,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] s_n;
    logic [3:0] gnt_n;
    logic       q_n, v_n;
    logic [1:0] winner, idx;
    logic       found;
    logic       any_req;
    logic       hold_done;

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    assign hold_done = (cnt == HOLD_LAST);
`else
    assign hold_done = 1'b0;
    // Hold limit is not built; the parameters only have to stay legal.
    if (HOLD_MAX < 1 || HOLD_MAX > 15 || CNT_W < 1) begin : g_illegal_hold_params
    end
`endif

    assign any_req = |REQ;
    assign BUSY    = (state == GRANT);

    // First requester found walking upward from ptr, wrapping mod 4.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && REQ[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        s_n     = S;
        gnt_n   = GNT;
        q_n     = Q;
        v_n     = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE, RELEASE: begin
                if (any_req) begin
                    state_n = GRANT;
                    s_n     = winner;
                    gnt_n   = 4'b0001 << winner;
`ifdef MUX4_ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                // The owner's last data bit is still delivered on a timeout edge.
                if (REQ[S]) begin
                    q_n = D[S];
                    v_n = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
                    cnt_n = cnt + CNT_W'(1);
`endif
                end
                if (!REQ[S] || hold_done) begin
                    state_n = RELEASE;
                    gnt_n   = 4'b0000;
                    ptr_n   = S + 2'd1;
`ifdef MUX4_ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            S     <= 2'd0;
            GNT   <= 4'b0000;
            Q     <= 1'b0;
            V     <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            S     <= s_n;
            GNT   <= gnt_n;
            Q     <= q_n;
            V     <= v_n;
`ifdef MUX4_ARB_TIMEOUT_EN
            cnt   <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter: vector table plus hand-written
// rotation, mid-grant reset and held-request sequences.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] REQ;
    logic [3:0] D;
    logic [1:0] S;
    logic [3:0] GNT;
    logic       Q;
    logic       V;
    logic       BUSY;

    int compared;
    int mismatched;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] d;
        logic [1:0] s;
        logic [3:0] gnt;
        logic       q;
        logic       v;
        logic       busy;
    } vec_t;

    vec_t vecs[21];

    mux4_rr_arbiter #(
        .HOLD_MAX(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .REQ(REQ),
        .D(D),
        .S(S),
        .GNT(GNT),
        .Q(Q),
        .V(V),
        .BUSY(BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, clock one edge, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic [3:0] req, input logic [3:0] d);
        rst = r;
        REQ = req;
        D   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] es, input logic [3:0] eg,
                               input logic eq, input logic ev, input logic eb);
        compared++;
        if (S !== es || GNT !== eg || Q !== eq || V !== ev || BUSY !== eb) begin
            mismatched++;
            $display("[TB] FAIL %s: got S=%0d GNT=%b Q=%b V=%b BUSY=%b, expected S=%0d GNT=%b Q=%b V=%b BUSY=%b",
                     name, S, GNT, Q, V, BUSY, es, eg, eq, ev, eb);
        end
    endtask

    initial begin
        logic [1:0] order [4];
        logic [1:0] o;
        logic [3:0] oh;

        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        REQ = 4'b0000;
        D   = 4'b0000;

        //          rst   req      d        s     gnt      q     v     busy
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 4'b0001, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 4'b0100, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 4'b0101, 4'b0100, 2'd2, 4'b0100, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'b0001, 4'b0000, 2'd2, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b1011, 4'b0000, 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 4'b1000, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'b1000, 4'b0000, 2'd3, 4'b1000, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'b0011, 4'b0000, 2'd3, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'b0011, 4'b0011, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 4'b0110, 4'b0110, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 4'b0010, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 4'b0110, 4'b0010, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].s, vecs[i].gnt, vecs[i].q,
                        vecs[i].v, vecs[i].busy);
        end

        // Rotation between requesters 1 and 3, each dropping after one data cycle.
        order[0] = 2'd1;
        order[1] = 2'd3;
        order[2] = 2'd1;
        order[3] = 2'd3;
        applyStimulus(1'b1, 4'b1010, 4'b0000);
        checkOutput("rot_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            o  = order[k];
            oh = 4'b0001 << o;
            applyStimulus(1'b0, 4'b1010, 4'b0000);
            checkOutput($sformatf("rot%0d_grant", k), o, oh, 1'b0, 1'b0, 1'b1);
            applyStimulus(1'b0, 4'b1010, 4'b0000);
            checkOutput($sformatf("rot%0d_data", k), o, oh, 1'b0, 1'b1, 1'b1);
            applyStimulus(1'b0, 4'b1010 & ~oh, 4'b0000);
            checkOutput($sformatf("rot%0d_release", k), o, 4'b0000, 1'b0, 1'b0, 1'b0);
        end

        // Reset in the middle of owner 2's grant must restart priority at 0.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b0100, 4'b0100);
        checkOutput("mid_grant2", 2'd2, 4'b0100, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0100);
        checkOutput("mid_data2", 2'd2, 4'b0100, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'b0101, 4'b0100);
        checkOutput("mid_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0101, 4'b0100);
        checkOutput("mid_regrant0", 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1);

        // All requests held high.
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        checkOutput("hold_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
`ifdef MUX4_ARB_TIMEOUT_EN
        for (int g = 0; g < 5; g++) begin
            o  = 2'(g % 4);
            oh = 4'b0001 << o;
            applyStimulus(1'b0, 4'b1111, 4'b0000);
            checkOutput($sformatf("to%0d_grant", g), o, oh, 1'b0, 1'b0, 1'b1);
            for (int c = 0; c < 4; c++) begin
                applyStimulus(1'b0, 4'b1111, 4'b0000);
                if (c < 3)
                    checkOutput($sformatf("to%0d_v%0d", g, c), o, oh, 1'b0, 1'b1, 1'b1);
                else
                    checkOutput($sformatf("to%0d_v%0d", g, c), o, 4'b0000, 1'b0, 1'b1, 1'b0);
            end
        end
`else
        applyStimulus(1'b0, 4'b1111, 4'b0000);
        checkOutput("hold_first", 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c < 20; c++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000);
            checkOutput($sformatf("hold%0d", c), 2'd0, 4'b0001, 1'b0, 1'b1, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
